// File: rtl/sram_1r1w.sv
// rtl/sram_1r1w.sv - one-read one-write synchronous SRAM with configurable read-during-write policy
module sram_1r1w #(
    parameter int    SIZE              = 64,
    parameter int    DATA_WIDTH        = 32,
    parameter string READ_DURING_WRITE = "NEW_DATA",
    localparam int   ADDR_WIDTH        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_adr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_adr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    // Only NEW_DATA needs the forwarding path; DONT_CARE behaves as OLD_DATA.
    localparam bit BYPASS = (READ_DURING_WRITE == "NEW_DATA");

    // One extra bit so SIZE itself is representable when SIZE is a power of two.
    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

    // Flag an unsupported policy string while elaborating.
    if (READ_DURING_WRITE != "NEW_DATA" &&
        READ_DURING_WRITE != "OLD_DATA" &&
        READ_DURING_WRITE != "DONT_CARE") begin : g_rdw_illegal
        $error("sram_1r1w: unsupported READ_DURING_WRITE value %s", READ_DURING_WRITE);
    end

    logic [DATA_WIDTH-1:0] mem_q [0:SIZE-1];

    logic                  rd_in_range;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] rd_data_d,   rd_data_q;
    logic                  byp_d,       byp_q;
    logic [DATA_WIDTH-1:0] byp_data_d,  byp_data_q;

    // Address decode and next-state for the read register and the forwarding register.
    always_comb begin
        rd_in_range = ({1'b0, read_adr} < SIZE_W);
        wr_fire     = write_en && ({1'b0, write_adr} < SIZE_W);
        rd_data_d   = rd_data_q;
        byp_d       = byp_q;
        byp_data_d  = byp_data_q;
        if (read_en) begin
            rd_data_d  = rd_in_range ? mem_q[read_adr] : '0;
            byp_d      = BYPASS && wr_fire && (read_adr == write_adr);
            byp_data_d = write_data;
        end
    end

    // Array write port; deliberately ignores reset so a loader can fill memory during reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[write_adr] <= write_data;
        end
    end

    // Registered read side; reset clears only the output path, never the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign read_data = byp_q ? byp_data_q : rd_data_q;

endmodule

// File: tb/tb_sram_1r1w.sv
// tb/tb_sram_1r1w.sv - directed self-checking bench for sram_1r1w
module tb_sram_1r1w;

    logic        clk;
    logic        reset;
    logic        read_en;
    logic [5:0]  read_adr;
    logic        write_en;
    logic [5:0]  write_adr;
    logic [31:0] write_data;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;

    int checks;
    int failures;

    // 64-word NEW_DATA instance
    sram_1r1w #(.SIZE(64), .DATA_WIDTH(32), .READ_DURING_WRITE("NEW_DATA")) dut_a (
        .clk        (clk),
        .reset      (reset),
        .read_en    (read_en),
        .read_adr   (read_adr),
        .read_data  (read_data_a),
        .write_en   (write_en),
        .write_adr  (write_adr),
        .write_data (write_data)
    );

    // 48-word OLD_DATA instance sharing the same stimulus
    sram_1r1w #(.SIZE(48), .DATA_WIDTH(32), .READ_DURING_WRITE("OLD_DATA")) dut_b (
        .clk        (clk),
        .reset      (reset),
        .read_en    (read_en),
        .read_adr   (read_adr),
        .read_data  (read_data_b),
        .write_en   (write_en),
        .write_adr  (write_adr),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic [5:0] ra,
                         input logic we, input logic [5:0] wa, input logic [31:0] wd);
        read_en    = re;
        read_adr   = ra;
        write_en   = we;
        write_adr  = wa;
        write_data = wd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        step();
        step();
        check_eq("reset_a", read_data_a, 32'h0);
        check_eq("reset_b", read_data_b, 32'h0);

        // Load during reset; reads requested meanwhile are discarded
        drive(1'b1, 6'd0, 1'b1, 6'd0, 32'h11);
        step();
        check_eq("rst_load0", read_data_a, 32'h0);
        drive(1'b1, 6'd0, 1'b1, 6'd63, 32'h22);
        step();
        check_eq("rst_load63", read_data_a, 32'h0);
        check_eq("rst_load63_b", read_data_b, 32'h0);

        reset = 1'b0;
        drive(1'b1, 6'd0, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("post_rst_rd0_a", read_data_a, 32'h11);
        check_eq("post_rst_rd0_b", read_data_b, 32'h11);
        drive(1'b1, 6'd63, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("post_rst_rd63_a", read_data_a, 32'h22);
        check_eq("post_rst_rd63_b_oor", read_data_b, 32'h0);

        // Basic write then read
        drive(1'b0, 6'd0, 1'b1, 6'd5, 32'hDEADBEEF);
        step();
        drive(1'b1, 6'd5, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("wr_rd5_a", read_data_a, 32'hDEADBEEF);
        check_eq("wr_rd5_b", read_data_b, 32'hDEADBEEF);

        // Same-address read during write
        drive(1'b0, 6'd0, 1'b1, 6'd3, 32'hAAAA0000);
        step();
        drive(1'b1, 6'd3, 1'b1, 6'd3, 32'h12345678);
        step();
        check_eq("rdw_new_a", read_data_a, 32'h12345678);
        check_eq("rdw_old_b", read_data_b, 32'hAAAA0000);
        drive(1'b1, 6'd3, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("rdw_after_a", read_data_a, 32'h12345678);
        check_eq("rdw_after_b", read_data_b, 32'h12345678);

        // Different addresses in the same cycle do not interact
        drive(1'b1, 6'd3, 1'b1, 6'd4, 32'h44);
        step();
        check_eq("diff_adr_a", read_data_a, 32'h12345678);
        check_eq("diff_adr_b", read_data_b, 32'h12345678);

        // Hold while read_en is low, even as the word is rewritten
        drive(1'b0, 6'd0, 1'b1, 6'd7, 32'h77);
        step();
        drive(1'b1, 6'd7, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("hold_load", read_data_a, 32'h77);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 6'(k), 1'b1, 6'd7, 32'h99);
            step();
            check_eq("hold_a", read_data_a, 32'h77);
            check_eq("hold_b", read_data_b, 32'h77);
        end

        // Address beyond SIZE on the 48-word instance
        drive(1'b0, 6'd0, 1'b1, 6'd50, 32'h00000BAD);
        step();
        drive(1'b1, 6'd50, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("oor_a", read_data_a, 32'h00000BAD);
        check_eq("oor_b", read_data_b, 32'h0);

        // Streaming: write i each cycle while reading i-1
        for (int i = 0; i < 64; i++) begin
            drive(i != 0, 6'(i - 1), 1'b1, 6'(i), i * 3);
            step();
            if (i != 0) begin
                check_eq("stream_a", read_data_a, (i - 1) * 3);
                check_eq("stream_b", read_data_b, (i - 1 < 48) ? (i - 1) * 3 : 0);
            end
        end

        // Asynchronous reset mid-stream
        drive(1'b0, 6'd0, 1'b1, 6'd9, 32'h55);
        step();
        drive(1'b1, 6'd9, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("pre_async_rst", read_data_a, 32'h55);
        drive(1'b1, 6'd9, 1'b0, 6'd0, 32'h0);
        reset = 1'b1;
        #1;
        check_eq("async_rst_a", read_data_a, 32'h0);
        check_eq("async_rst_b", read_data_b, 32'h0);
        step();
        check_eq("async_rst_hold", read_data_a, 32'h0);
        reset = 1'b0;
        step();
        check_eq("mem_kept9_a", read_data_a, 32'h55);
        check_eq("mem_kept9_b", read_data_b, 32'h55);
        drive(1'b1, 6'd10, 1'b0, 6'd0, 32'h0);
        step();
        check_eq("mem_kept10", read_data_a, 32'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
